// File: rtl/uart_rx_frame_unpack.sv
// uart_rx_frame_unpack: 8N1 UART receiver that unpacks each byte into eight 1-bit pixels (FF/00), MSB first, with frame counting and idle abort
module uart_rx_frame_unpack #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int FRAME_BYTES  = 5160,
    parameter int IDLE_TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       pix_ready,
    output logic       pix_de,
    output logic [7:0] pix_data,
    output logic       frame_done,
    output logic       frame_abort,
    output logic       rx_err,
    output logic       overrun
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);
    localparam int BW      = $clog2(FRAME_BYTES + 1);
    localparam int IW      = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state, w_state_nx;
    logic            r_rx_meta, r_rx_sync;
    logic [DW-1:0]   r_div;
    logic [3:0]      r_tcnt;
    logic [2:0]      r_bcnt;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_buf, r_sh;
    logic            r_buf_valid, r_buf_last, r_sh_valid, r_sh_last;
    logic [2:0]      r_idx;
    logic [BW-1:0]   r_byte_cnt;
    logic [IW-1:0]   r_idle;
    logic            w_tick, w_bit_sample, w_stop_sample, w_byte_done, w_frm_err;
    logic            w_hs, w_sh_free, w_load, w_timeout, w_last_byte;

    assign w_tick        = r_div == DW'(DIV - 1);
    assign w_bit_sample  = w_tick && r_tcnt == 4'd15;
    assign w_stop_sample = r_state == S_STOP && w_bit_sample;
    assign w_byte_done   = w_stop_sample && r_rx_sync;
    assign w_frm_err     = w_stop_sample && !r_rx_sync;
    assign w_hs          = r_sh_valid && pix_ready;
    assign w_sh_free     = !r_sh_valid || (w_hs && r_idx == 3'd7);
    assign w_load        = w_sh_free && r_buf_valid;
    assign w_last_byte   = r_byte_cnt == BW'(FRAME_BYTES - 1);
    assign w_timeout     = r_byte_cnt != '0 && r_idle == IW'(IDLE_TIMEOUT) && !w_byte_done;

    // Outputs are forced quiet while reset is asserted, even in its first cycle
    assign pix_de      = !reset && r_sh_valid;
    assign pix_data    = {8{!reset && r_sh_valid && r_sh[7]}};
    assign frame_done  = !reset && w_hs && r_idx == 3'd7 && r_sh_last;
    assign frame_abort = !reset && w_timeout;
    assign rx_err      = !reset && w_frm_err;
    assign overrun     = !reset && w_byte_done && r_buf_valid;

    // Input synchronizer and free-running 16x oversample tick divider
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_div     <= '0;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_div     <= w_tick ? '0 : r_div + DW'(1);
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else r_state <= w_state_nx;
    end

    // Receiver next-state: start is re-checked mid-bit so short glitches fall back to idle
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (!r_rx_sync) w_state_nx = S_START;
            S_START: if (w_tick && r_tcnt == 4'd7) w_state_nx = r_rx_sync ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_sample && r_bcnt == 3'd7) w_state_nx = S_STOP;
            S_STOP:  if (w_bit_sample) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Tick/bit counters restart on every state change; data shifts in LSB first
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt     <= '0;
            r_bcnt     <= '0;
            r_rx_shift <= '0;
        end else begin
            r_tcnt <= (r_state == S_IDLE || w_state_nx != r_state) ? 4'd0 : w_tick ? r_tcnt + 4'd1 : r_tcnt;
            r_bcnt <= r_state == S_IDLE ? 3'd0 : (r_state == S_DATA && w_bit_sample) ? r_bcnt + 3'd1 : r_bcnt;
            if (r_state == S_DATA && w_bit_sample) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        end
    end

    // Holding buffer, byte counter and pixel unpack shifter; timeout flushes like reset
    always_ff @(posedge clk) begin
        if (reset || w_timeout) begin
            r_buf       <= '0;
            r_buf_valid <= 1'b0;
            r_buf_last  <= 1'b0;
            r_sh        <= '0;
            r_sh_valid  <= 1'b0;
            r_sh_last   <= 1'b0;
            r_idx       <= '0;
            r_byte_cnt  <= '0;
        end else begin
            if (w_byte_done && !r_buf_valid) begin
                r_buf       <= r_rx_shift;
                r_buf_valid <= 1'b1;
                r_buf_last  <= w_last_byte;
                r_byte_cnt  <= w_last_byte ? '0 : r_byte_cnt + BW'(1);
            end else if (w_load) begin
                r_buf_valid <= 1'b0;
            end
            if (w_load) begin
                r_sh       <= r_buf;
                r_sh_last  <= r_buf_last;
                r_sh_valid <= 1'b1;
                r_idx      <= '0;
            end else if (w_hs) begin
                r_sh       <= {r_sh[6:0], 1'b0};
                r_idx      <= r_idx + 3'd1;
                r_sh_valid <= r_idx != 3'd7;
            end
        end
    end

    // Idle counter runs only inside a partial frame and restarts on every received byte
    always_ff @(posedge clk) begin
        if (reset || w_byte_done || w_timeout) r_idle <= '0;
        else if (r_byte_cnt != '0) r_idle <= r_idle + IW'(1);
    end
endmodule

// File: doc/uart_rx_frame_unpack.md
UART_RX_FRAME_UNPACK -- requirements
Module: uart_rx_frame_unpack

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate.
REQ-003 Parameter FRAME_BYTES, default 5160, packed bytes per frame (8 pixels per byte).
REQ-004 Parameter IDLE_TIMEOUT, default 1_000_000, clock cycles of byte silence that abort a partial frame.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 rx  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-009 pix_ready  input  1  downstream accepts pixel when high with pix_de.
REQ-010 pix_de  output  1  pixel valid.
REQ-011 pix_data  output  8  pixel value, 8'hFF (edge) or 8'h00, same format as the canny stream.
REQ-012 frame_done  output  1  one-cycle pulse on acceptance of last pixel of a frame.
REQ-013 frame_abort  output  1  one-cycle pulse when the idle timeout discards a partial frame.
REQ-014 rx_err  output  1  one-cycle pulse on framing error (stop bit sampled low).
REQ-015 overrun  output  1  one-cycle pulse when a received byte is dropped for lack of buffer space.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-017 A sample tick SHALL be generated every CLK_FREQ/(BAUD*16) cycles (integer division, minimum 1), free-running from reset.
REQ-018 Receiver FSM states: IDLE, START, DATA, STOP; reset state IDLE.
REQ-019 IDLE->START on synchronized rx low; START waits 8 ticks, then ->DATA if rx still low, else ->IDLE (glitch rejection, no pulse).
REQ-020 DATA samples rx every 16 ticks, shifting in 8 bits LSB first, then ->STOP.
REQ-021 STOP samples rx after 16 ticks: high -> byte complete; low -> rx_err pulse, byte discarded; both ->IDLE.
REQ-022 Datapath: one-byte holding buffer plus 8-bit unpack shifter with 3-bit pixel index.
REQ-023 Byte complete with holding buffer empty SHALL write buffer (valid the next cycle) and increment byte counter.
REQ-024 Byte complete with holding buffer full SHALL drop the byte, pulse overrun, leave byte counter unchanged.
REQ-025 Shifter SHALL load from holding buffer in any cycle it is empty or its last pixel is handshaken, freeing the buffer that cycle.
REQ-026 Latency: first pix_de of a byte 2 cycles after the stop-bit sample cycle when shifter is idle.
REQ-027 pix_data = 8'hFF when current bit is 1, else 8'h00; bit 7 emitted first, bit 0 last.
REQ-028 Pixel advances only on pix_de && pix_ready; pix_de and pix_data SHALL hold stable while pix_ready is low.
REQ-029 Byte counter counts 0..FRAME_BYTES-1 and wraps to 0 when byte FRAME_BYTES is accepted into the buffer.
REQ-030 frame_done SHALL pulse in the cycle of the bit-0 handshake of the FRAME_BYTES-th byte.
REQ-031 Idle counter SHALL reset on every completed byte and count only while byte counter is nonzero.
REQ-032 Idle counter reaching IDLE_TIMEOUT SHALL pulse frame_abort, clear byte counter, holding buffer and shifter; pix_de low next cycle.
REQ-033 Timeout coinciding with byte completion: byte completion wins, no abort.
REQ-034 rx_err SHALL not alter byte counter or datapath.

Reset
REQ-035 During reset: pix_de, frame_done, frame_abort, rx_err, overrun = 0; pix_data = 8'h00; FSM IDLE; counters, buffer, shifter cleared.
REQ-036 Reset mid-byte or mid-frame SHALL discard all partial data; first byte after reset is byte 0 of a new frame.

Verification (CLK_FREQ=1_600_000, BAUD=100_000, FRAME_BYTES=4, IDLE_TIMEOUT=500)
REQ-037 Send 0xA5, pix_ready=1 -> 8 consecutive pixels FF,00,FF,00,00,FF,00,FF; first pix_de 2 cycles after stop sample.
REQ-038 Send 0x81,0x00,0x00,0x01 -> 32 pixels; frame_done high exactly with 32nd handshake; next byte restarts at byte 0.
REQ-039 Send 0x3C with stop bit low -> rx_err one pulse, no pix_de, byte counter unchanged.
REQ-040 Hold pix_ready=0, send 3 bytes -> bytes 1,2 retained, byte 3 dropped with one overrun pulse; releasing pix_ready yields 16 pixels.
REQ-041 Send 2 bytes, then 500 idle cycles -> frame_abort one pulse, pix_de low; next 4 bytes produce one frame_done.
REQ-042 4-clock low glitch on rx in IDLE -> FSM returns IDLE, no outputs pulse.
